mem_port_arbiter: RTL

// Shares one single-port unified memory between the core's instruction-fetch path and its load/store path.

---
 rtl/core_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/arb_latency_counter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Owner/state encodings and the word-align helper live here so the top and bench agree.
package core_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_e;

  localparam logic [3:0] BE_ALL = 4'hF;
  // Wide enough for the largest legal latency (7).
  localparam int LAT_W = 3;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (fetch + load/store) and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the view of the core and memory macro around it.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_latency_counter.sv
// Loadable down-counter tracking the fixed memory read latency.
// last marks the cycle the read data is on the memory bus.
module arb_latency_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         last
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign busy = (cnt_reg != '0);
  assign last = (cnt_reg == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// One access per MEM_LAT cycles; fetch is forced in after MAX_DATA_BURST data grants.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int MEM_LAT        = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int             BW        = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_DATA_BURST);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

  arb_state_e    state_reg, state_next;
  arb_owner_e    owner_reg, owner_next;
  logic          we_reg, we_next;
  logic [BW-1:0] burst_reg, burst_next;

  logic lat_busy;
  logic lat_last;
  logic slot_open;
  logic rsp_fire;
  logic fetch_wins;
  logic pick_fetch;
  logic pick_data;

  arb_latency_counter #(.W(LAT_W)) u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pick_fetch | pick_data),
    .load_val (LAT_LOAD),
    .busy     (lat_busy),
    .last     (lat_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= OWN_FETCH;
      we_reg    <= 1'b0;
      burst_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      burst_reg <= burst_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    we_next    = we_reg;
    burst_next = burst_reg;

    // A new grant can overlap the response cycle of the previous access.
    slot_open  = !lat_busy || lat_last;
    rsp_fire   = rst_n && (state_reg == BUSY) && lat_last;
    fetch_wins = bus.if_req && (!bus.dm_req || (burst_reg == BURST_MAX));
    pick_fetch = rst_n && slot_open && fetch_wins;
    pick_data  = rst_n && slot_open && bus.dm_req && !fetch_wins;

    if (pick_fetch || pick_data) begin
      state_next = BUSY;
      owner_next = pick_data ? OWN_DATA : OWN_FETCH;
      we_next    = pick_data && bus.dm_we;
    end else if (rsp_fire) begin
      state_next = IDLE;
    end

    // Burst only counts data grants that actually made fetch wait.
    if (!bus.if_req || pick_fetch) begin
      burst_next = '0;
    end else if (pick_data && (burst_reg != BURST_MAX)) begin
      burst_next = burst_reg + BW'(1);
    end
  end

  assign bus.if_gnt    = pick_fetch;
  assign bus.dm_gnt    = pick_data;
  assign bus.mem_req   = pick_fetch | pick_data;
  assign bus.mem_we    = pick_data & bus.dm_we;
  assign bus.mem_be    = pick_data  ? (bus.dm_we ? bus.dm_be : BE_ALL) :
                         pick_fetch ? BE_ALL : 4'h0;
  assign bus.mem_addr  = pick_data  ? word_addr(bus.dm_addr) :
                         pick_fetch ? word_addr(bus.if_addr) : 32'h0;
  assign bus.mem_wdata = (pick_data && bus.dm_we) ? bus.dm_wdata : 32'h0;

  assign bus.if_rvalid = rsp_fire && (owner_reg == OWN_FETCH);
  assign bus.dm_rvalid = rsp_fire && (owner_reg == OWN_DATA);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
  // Store acks return zero data.
  assign bus.dm_rdata  = (bus.dm_rvalid && !we_reg) ? bus.mem_rdata : 32'h0;

endmodule
